// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: default widths,
// the NOP encoding presented when the queue is empty, and the reset fetch address.
package ifetch_queue_pkg;

  localparam int          DATA_WIDTH_DEF = 16;
  localparam int          ADDR_WIDTH_DEF = 16;
  localparam logic [15:0] NOP            = 16'h0000;
  localparam logic [15:0] RESET_PC_DEF   = 16'h0000;

endpackage

// File: rtl/ifetch_queue_fetch_fifo.sv
// DEPTH-entry ring of {inst, pc}; head is read combinationally from registered storage.
// Pointers wrap naturally at log2(DEPTH) bits; flush empties the ring in one cycle.
module ifetch_queue_fetch_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [DATA_WIDTH-1:0]      inst_i,
  input  logic [ADDR_WIDTH-1:0]      pc_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic [DATA_WIDTH-1:0]      head_inst_o,
  output logic [ADDR_WIDTH-1:0]      head_pc_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      inst_mem[wr_ptr_q] <= inst_i;
      pc_mem[wr_ptr_q]   <= pc_i;
    end
  end

  assign level_o     = level_q;
  assign head_inst_o = inst_mem[rd_ptr_q];
  assign head_pc_o   = pc_mem[rd_ptr_q];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues sequential reads to a 1-cycle synchronous memory,
// buffers returned words with their PCs, and presents them to decode under stall/branch control.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       mem_req_o,
  output logic [ADDR_WIDTH-1:0]      mem_addr_o,
  input  logic [DATA_WIDTH-1:0]      mem_data_i,
  input  logic                       branch_i,
  input  logic [ADDR_WIDTH-1:0]      branch_addr_i,
  input  logic                       stall_i,
  output logic                       valid_o,
  output logic [DATA_WIDTH-1:0]      inst_o,
  output logic [ADDR_WIDTH-1:0]      pc_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int LW = $clog2(DEPTH+1);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] issue_pc_q, issue_pc_d;
  logic                  inflight_q, inflight_d;
  logic                  squash_q, squash_d;

  logic [LW-1:0]         level;
  logic [LW:0]           credit_used;
  logic [DATA_WIDTH-1:0] head_inst;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic                  issue, push, pop, valid;

  always_comb begin
    // Credit counts the outstanding read against free slots; a same-cycle pop is not credited.
    credit_used = {1'b0, level} + (LW+1)'(inflight_q);
    issue       = rst && !branch_i && (credit_used < (LW+1)'(DEPTH));
    valid       = (level != '0);
    push        = inflight_q && !squash_q && !branch_i;
    pop         = valid && !stall_i && !branch_i;

    fetch_pc_d = fetch_pc_q;
    if (branch_i)   fetch_pc_d = branch_addr_i;
    else if (issue) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);

    issue_pc_d = issue ? fetch_pc_q : issue_pc_q;
    inflight_d = issue;
    squash_d   = branch_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      issue_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
    end
  end

  ifetch_queue_fetch_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (branch_i),
    .inst_i      (mem_data_i),
    .pc_i        (issue_pc_q),
    .level_o     (level),
    .head_inst_o (head_inst),
    .head_pc_o   (head_pc)
  );

  assign mem_req_o  = issue;
  assign mem_addr_o = fetch_pc_q;
  assign valid_o    = valid;
  assign inst_o     = valid ? head_inst : DATA_WIDTH'(NOP);
  assign pc_o       = valid ? head_pc : '0;
  assign level_o    = level;

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: the stimulus side predicts the PC stream decode should
// see (sequential from each restart point) and when valid_o must appear; a monitor checks it.
module tb_ifetch_queue;

  logic        clk;
  logic        rst;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic [15:0] mem_data_i;
  logic        branch_i;
  logic [15:0] branch_addr_i;
  logic        stall_i;
  logic        valid_o;
  logic [15:0] inst_o;
  logic [15:0] pc_o;
  logic [2:0]  level_o;

  ifetch_queue dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_i    (mem_data_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .stall_i       (stall_i),
    .valid_o       (valid_o),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .level_o       (level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          valid_due = 1 << 30;
  logic [15:0] exp_q[$];
  logic [15:0] exp_tail = 16'h0;

  function automatic logic [15:0] memfn(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, req);
    end
  endtask

  // One clock cycle: memory answers the request seen at the edge, then new inputs are applied.
  task automatic cycle(input bit br, input logic [15:0] ba, input bit st);
    logic        req;
    logic [15:0] addr;
    @(posedge clk);
    req  = mem_req_o;
    addr = mem_addr_o;
    #1;
    cyc++;
    mem_data_i    = req ? memfn(addr) : 16'($urandom);
    branch_i      = br;
    branch_addr_i = ba;
    stall_i       = st;
    if (br) begin
      exp_q.delete();
      exp_q.push_back(ba);
      exp_tail  = ba + 16'h1;
      valid_due = cyc + 3;
    end else begin
      exp_q.push_back(exp_tail);
      exp_tail = exp_tail + 16'h1;
    end
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    cyc++;
    mem_data_i = 16'($urandom);
    branch_i   = 1'b0;
    stall_i    = 1'b0;
    rst        = 1'b1;
    exp_q.delete();
    exp_q.push_back(16'h0000);
    exp_tail  = 16'h0001;
    valid_due = cyc + 2;
  endtask

  // Monitor: checks presentation timing, empty-output values and the accepted stream.
  logic [15:0] mon_pc;
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (!branch_i) chk("valid_timing", {31'b0, valid_o}, {31'b0, (cyc >= valid_due)});
        else           chk("req_during_branch", {31'b0, mem_req_o}, 32'h0);
        chk("level_bound", {31'b0, (level_o <= 3'd4)}, 32'h1);
        if (!valid_o) begin
          chk("empty_inst", {16'h0, inst_o}, 32'h0);
          chk("empty_pc", {16'h0, pc_o}, 32'h0);
        end else if (!stall_i && !branch_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pop", {16'h0, pc_o}, 32'hFFFF_FFFF);
          end else begin
            mon_pc = exp_q.pop_front();
            chk("pc_stream", {16'h0, pc_o}, {16'h0, mon_pc});
            chk("inst_stream", {16'h0, inst_o}, {16'h0, memfn(mon_pc)});
          end
        end
      end
    end
  end

  bit stall_mode;
  bit br;
  logic [15:0] tgt;

  initial begin
    rst           = 1'b0;
    mem_data_i    = 16'h0;
    branch_i      = 1'b0;
    branch_addr_i = 16'h0;
    stall_i       = 1'b0;
    repeat (3) cycle(0, 16'h0, 0);
    @(negedge clk);
    chk("rst_req", {31'b0, mem_req_o}, 32'h0);
    chk("rst_addr", {16'h0, mem_addr_o}, 32'h0);
    chk("rst_valid", {31'b0, valid_o}, 32'h0);
    chk("rst_level", {29'b0, level_o}, 32'h0);

    // Startup stream
    release_rst();
    @(negedge clk);
    chk("startup_req", {31'b0, mem_req_o}, 32'h1);
    repeat (8) cycle(0, 16'h0, 0);

    // Stall held until the queue saturates, then drain
    repeat (8) cycle(0, 16'h0, 1);
    @(negedge clk);
    chk("stall_level", {29'b0, level_o}, 32'h4);
    chk("stall_req", {31'b0, mem_req_o}, 32'h0);
    repeat (10) cycle(0, 16'h0, 0);

    // Branch from a full queue
    repeat (6) cycle(0, 16'h0, 1);
    cycle(1, 16'h0040, 0);
    cycle(0, 16'h0, 0);
    @(negedge clk);
    chk("branch_req", {31'b0, mem_req_o}, 32'h1);
    chk("branch_addr", {16'h0, mem_addr_o}, 32'h0040);
    repeat (6) cycle(0, 16'h0, 0);

    // Back-to-back branches, last wins
    cycle(1, 16'h0020, 0);
    cycle(1, 16'h0030, 0);
    repeat (6) cycle(0, 16'h0, 0);

    // Address wrap
    cycle(1, 16'hFFFE, 0);
    repeat (8) cycle(0, 16'h0, 0);

    // Asynchronous reset between edges
    cycle(0, 16'h0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_req", {31'b0, mem_req_o}, 32'h0);
    chk("async_addr", {16'h0, mem_addr_o}, 32'h0);
    chk("async_valid", {31'b0, valid_o}, 32'h0);
    chk("async_inst", {16'h0, inst_o}, 32'h0);
    chk("async_pc", {16'h0, pc_o}, 32'h0);
    chk("async_level", {29'b0, level_o}, 32'h0);
    repeat (2) cycle(0, 16'h0, 0);
    release_rst();
    repeat (8) cycle(0, 16'h0, 0);

    // Randomized traffic
    stall_mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) stall_mode = !stall_mode;
      br  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
      cycle(br, tgt, stall_mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0));
    end
    repeat (10) cycle(0, 16'h0, 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
